// File: rtl/rtlola_sched_pkg.sv
// Shared definitions for the RTLola evaluation scheduler: default widths,
// the default-width event record and the packed event width helper.
package rtlola_sched_pkg;

  localparam int DATA_W_DEF     = 64;
  localparam int TS_W_DEF       = 64;
  localparam int NUM_LAYERS_DEF = 4;

  // Field order matches the flat vector stored in the event FIFO (MSB first).
  typedef struct packed {
    logic [DATA_W_DEF-1:0] value;
    logic [TS_W_DEF-1:0]   ts;
    logic                  has_input;
    logic                  periodic;
  } sched_event_t;

  function automatic int event_bits(input int data_w, input int ts_w);
    return data_w + ts_w + 2;
  endfunction

endpackage

// File: rtl/rtlola_event_fifo.sv
// Depth-parameterised event FIFO. A push into a full FIFO is accepted when a
// pop happens at the same edge; reads are from the head with no bypass.
module rtlola_event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign push_ok = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rtlola_eval_scheduler.sv
// RTLola monitor front end: timestamps inputs and periodic deadlines, queues
// them as events and walks each popped event through the layer enable chain.
module rtlola_eval_scheduler
  import rtlola_sched_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int TS_W          = TS_W_DEF,
  parameter int QUEUE_DEPTH   = 4,
  parameter int PERIOD_CYCLES = 1000,
  parameter int NUM_LAYERS    = NUM_LAYERS_DEF,
  parameter int ISSUE_GAP     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_W-1:0]     input_0,
  input  logic                  new_input_0,
  output logic [DATA_W-1:0]     ev_value,
  output logic [TS_W-1:0]       ev_time,
  output logic                  ev_periodic,
  output logic                  q_push,
  output logic                  q_push_valid,
  output logic                  q_pop,
  output logic                  q_pop_valid,
  output logic                  enable_in0,
  output logic [NUM_LAYERS-1:0] enable_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam int EW  = event_bits(DATA_W, TS_W);
  localparam int DLW = $clog2(PERIOD_CYCLES);
  localparam int GW  = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [DLW-1:0] DL_RELOAD  = DLW'(PERIOD_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_RELOAD = GW'(ISSUE_GAP - 1);

  logic [TS_W-1:0] ts_cnt;
  logic [DLW-1:0]  dl_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            layer_vld;

  logic            dl_hit;
  logic            create;
  logic [EW-1:0]   wdata;
  logic [EW-1:0]   rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push_ok;

  assign dl_hit = (dl_cnt == '0);
  assign create = new_input_0 | dl_hit;
  assign wdata  = {(new_input_0 ? input_0 : {DATA_W{1'b0}}), ts_cnt, new_input_0, dl_hit};

  // Handshake: q_push/q_push_valid report last edge's push attempt/acceptance;
  // q_pop marks an open issue slot this cycle and q_pop_valid means the head
  // entry is removed at the edge that ends this cycle (slot open and non-empty).
  assign q_pop       = rst & en & (gap_cnt == '0);
  assign q_pop_valid = q_pop & ~fifo_empty;

  assign busy = ~fifo_empty | layer_vld | (|enable_out);

  rtlola_event_fifo #(
    .W     (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (en & create),
    .pop     (q_pop_valid),
    .wdata   (wdata),
    .rdata   (rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt       <= '0;
      dl_cnt       <= DL_RELOAD;
      gap_cnt      <= '0;
      layer_vld    <= 1'b0;
      q_push       <= 1'b0;
      q_push_valid <= 1'b0;
      overflow     <= 1'b0;
      ev_value     <= '0;
      ev_time      <= '0;
      ev_periodic  <= 1'b0;
      enable_in0   <= 1'b0;
      enable_out   <= '0;
    end else if (en) begin
      ts_cnt       <= ts_cnt + 1'b1;
      dl_cnt       <= dl_hit ? DL_RELOAD : dl_cnt - 1'b1;
      q_push       <= create;
      q_push_valid <= push_ok;
      // A drop only happens when full and nothing leaves at the same edge.
      if (create & fifo_full & ~q_pop_valid) overflow <= 1'b1;

      if (q_pop_valid)          gap_cnt <= GAP_RELOAD;
      else if (gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;

      layer_vld  <= q_pop_valid;
      enable_in0 <= q_pop_valid & rdata[1];
      if (q_pop_valid) begin
        ev_value    <= rdata[EW-1 -: DATA_W];
        ev_time     <= rdata[TS_W+1 -: TS_W];
        ev_periodic <= rdata[0];
      end
      // Layer k+1 follows layer k one cycle later, independent of has_input.
      enable_out <= (enable_out << 1) | NUM_LAYERS'(layer_vld);
    end
  end

endmodule

// File: doc/rtlola_eval_scheduler.md
Name: rtlola_eval_scheduler

Overview:
Front-end controller for the generated RTLola monitor pipeline. Timestamps input arrivals and self-generated periodic deadlines, buffers them as events in a small queue, and pops one event per issue slot. Each popped event is sequenced through the evaluation layers by a one-hot enable shift chain that drives the monitor's enable_in*/enable_out* and q_* signals. Sits between the stimulus/host interface and topEntity.

Parameters:
DATA_W, 64, width of input_0 value
TS_W, 64, timestamp counter width (cycles)
QUEUE_DEPTH, 4, event queue entries (power of 2, >=2)
PERIOD_CYCLES, 1000, cycles between periodic deadlines (>=2)
NUM_LAYERS, 4, evaluation layers after input layer; enable_out[k] fires at layer k+1
ISSUE_GAP, 1, minimum cycles between consecutive pops (1 = back-to-back)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
en  in  1  global enable; 0 freezes all state
input_0  in  DATA_W  input stream value, sampled with new_input_0
new_input_0  in  1  input event strobe, one cycle per event
ev_value  out  DATA_W  value of event in input layer
ev_time  out  TS_W  timestamp of event in input layer
ev_periodic  out  1  event in input layer carries a deadline
q_push  out  1  push attempted last cycle
q_push_valid  out  1  push accepted last cycle
q_pop  out  1  pop slot open this cycle
q_pop_valid  out  1  pop actually removes an entry this cycle
enable_in0  out  1  input layer evaluates input_0
enable_out  out  NUM_LAYERS  per-layer output enables
overflow  out  1  sticky: an event was dropped
busy  out  1  queue non-empty or any layer active

Behaviour:
- Reset (rst=0, async): queue empty, timestamp 0, deadline counter = PERIOD_CYCLES-1, gap counter 0, all outputs 0 (ev_* = 0).
- en=0: no state changes, strobes ignored, registered outputs hold.
- Timestamp: increments each en cycle, wraps mod 2^TS_W.
- Deadline counter: decrements each en cycle; at 0 raises periodic request, reloads PERIOD_CYCLES-1.
- Event creation, edge N: input (new_input_0=1) and/or deadline (counter=0) -> one entry {value, ts, has_input, periodic}; if simultaneous, merged into one entry with both flags. Deadline-only entry: value 0.
- Push: q_push=1 in cycle after edge N; q_push_valid=1 if the entry was written. Full queue with no pop at edge N -> entry dropped, q_push_valid=0, overflow=1 until reset. Full queue with pop at same edge -> push accepted.
- Pop: q_pop=1 when gap counter=0; q_pop_valid = q_pop & non-empty; pop at the edge ending that cycle. After pop, gap counter loads ISSUE_GAP-1.
- No bypass: entry written at edge N is poppable earliest at edge N+1.
- Issue chain: pop at edge P -> cycle after P: ev_value/ev_time/ev_periodic loaded, enable_in0 = has_input. enable_out[k] high in cycle P+2+k for that event (one cycle each); layers overlap for back-to-back events.
- Deadline-only event: enable_in0=0, enable_out chain still runs.
- Empty queue: q_pop may be 1, q_pop_valid=0, no chain start.
- Reset mid-operation: queue, chain, overflow cleared immediately; in-flight enables drop to 0.
- Queue order strictly FIFO; pointers wrap mod QUEUE_DEPTH.

Decomposition:
- Package rtlola_sched_pkg: event record typedef {value, ts, has_input, periodic}, TS_W/DATA_W defaults, layer-count constant.
- Sub-module rtlola_event_fifo: depth-parameterised FIFO with full/empty, simultaneous push/pop on full allowed; scheduler holds counters, issue chain, strobes.

Test Plan:
- Single input: input_0=1 at edge 10, empty queue -> q_push/q_push_valid at cycle 11, q_pop_valid cycle 11, enable_in0 + ev_value=1 cycle 12, enable_out[0..3] cycles 13..16.
- Back-to-back inputs 3,4 on consecutive edges, ISSUE_GAP=1 -> enable_in0 two consecutive cycles, values 3 then 4, enable_out[0] two consecutive cycles, FIFO order kept.
- PERIOD_CYCLES=8, no inputs -> deadline entry every 8 cycles, ev_periodic=1, enable_in0=0, enable_out chain runs, ev_time spacing 8.
- Input coincident with deadline, value 7 -> single entry: enable_in0=1, ev_periodic=1, ev_value=7; only one pop.
- QUEUE_DEPTH=4, ISSUE_GAP=8, 6 inputs values 6..11 back-to-back -> first popped, 4 stored, last dropped; q_push_valid=0 for dropped one, overflow=1; issued values 6..10.
- rst pulsed low mid-chain with 2 queued -> all enables 0 immediately, busy=0, overflow=0, timestamp restarts at 0.
